// File: rtl/graycounter_8_rdside_if.sv
`default_nettype none
// ============================================================================
//  Module   : graycounter_8_rdside_if
//  Brief    : Read-side gray pointer bundle for the 8-state PCS pointer FIFO.
//  Revision : 1.0  initial release
// ============================================================================
interface graycounter_8_rdside_if;
  logic [4:0] wr_gray;
  logic       rd_en;
  logic [2:0] rd_addr;
  logic [4:0] rd_gray;
  logic [2:0] fill;
  logic       empty;
  logic       almost_empty;
  logic       underflow;
  logic       code_err;

  modport master (
    output wr_gray, rd_en,
    input  rd_addr, rd_gray, fill, empty, almost_empty, underflow, code_err
  );

  modport slave (
    input  wr_gray, rd_en,
    output rd_addr, rd_gray, fill, empty, almost_empty, underflow, code_err
  );
endinterface
`default_nettype wire

// File: rtl/graycounter_8_rdside.sv
`default_nettype none
// ============================================================================
//  Module   : graycounter_8_rdside
//  Brief    : Read-side pointer logic of the 8-state gray-coded pointer FIFO:
//             writer pointer synchroniser/decoder, read pointer, fill flags.
//             Define GRAYRD_CHECK_EN to build the illegal-code checker.
//  Revision : 1.0  initial release
// ============================================================================
module graycounter_8_rdside #(
  parameter int SYNC_STAGES = 2,
  parameter int AEMPTY_LVL  = 1
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  graycounter_8_rdside_if.slave bus
);

  localparam logic [2:0] AEMPTY_THR = 3'(AEMPTY_LVL);

  // Returns {legal, index}; illegal codes map to index 7.
  function automatic logic [3:0] gray_decode(input logic [4:0] g);
    case (g)
      5'b00000: return {1'b1, 3'd0};
      5'b00001: return {1'b1, 3'd1};
      5'b00011: return {1'b1, 3'd2};
      5'b00010: return {1'b1, 3'd3};
      5'b00110: return {1'b1, 3'd4};
      5'b00111: return {1'b1, 3'd5};
      5'b00101: return {1'b1, 3'd6};
      5'b00100: return {1'b1, 3'd7};
      default:  return {1'b0, 3'd7};
    endcase
  endfunction

  function automatic logic [4:0] gray_encode(input logic [2:0] i);
    case (i)
      3'd0:    return 5'b00000;
      3'd1:    return 5'b00001;
      3'd2:    return 5'b00011;
      3'd3:    return 5'b00010;
      3'd4:    return 5'b00110;
      3'd5:    return 5'b00111;
      3'd6:    return 5'b00101;
      default: return 5'b00100;
    endcase
  endfunction

  logic [SYNC_STAGES-1:0][4:0] sync_q, sync_d;
  logic [2:0] wr_idx_q, wr_idx_d;
  logic [2:0] rd_idx_q, rd_idx_d;
  logic [4:0] rd_gray_q, rd_gray_d;
  logic       underflow_q, underflow_d;
  logic       code_err_q, code_err_d;

  logic [3:0] dec;
  logic       dec_legal;
  logic [2:0] dec_idx;
  logic [2:0] fill;
  logic       empty;
  logic       accept;

  assign dec       = gray_decode(sync_q[SYNC_STAGES-1]);
  assign dec_legal = dec[3];
  assign dec_idx   = dec[2:0];

  // Flags are derived from registered pointers only, so a same-edge accept and
  // writer update are both reflected in the following cycle.
  assign fill   = wr_idx_q - rd_idx_q;
  assign empty  = (fill == 3'd0);
  assign accept = bus.rd_en & ~empty;

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], bus.wr_gray};
    rd_idx_d    = rd_idx_q;
    rd_gray_d   = rd_gray_q;
    underflow_d = bus.rd_en & empty;
    wr_idx_d    = dec_idx;
    code_err_d  = 1'b0;
`ifdef GRAYRD_CHECK_EN
    if (!dec_legal) begin
      wr_idx_d = wr_idx_q;
    end
    code_err_d = code_err_q | ~dec_legal;
`endif
    if (accept) begin
      rd_idx_d  = rd_idx_q + 3'd1;
      rd_gray_d = gray_encode(rd_idx_q + 3'd1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q      <= '0;
      wr_idx_q    <= 3'd0;
      rd_idx_q    <= 3'd0;
      rd_gray_q   <= 5'b00000;
      underflow_q <= 1'b0;
      code_err_q  <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      rd_gray_q   <= rd_gray_d;
      underflow_q <= underflow_d;
      code_err_q  <= code_err_d;
    end
  end

`ifdef GRAYRD_CHECK_EN
  assign bus.code_err = code_err_q;
`else
  logic unused_code_err;
  logic unused_dec_legal;
  assign unused_code_err  = code_err_q;
  assign unused_dec_legal = dec_legal;
  assign bus.code_err     = 1'b0;
`endif

  assign bus.rd_addr      = rd_idx_q;
  assign bus.rd_gray      = rd_gray_q;
  assign bus.fill         = fill;
  assign bus.empty        = empty;
  assign bus.almost_empty = (fill <= AEMPTY_THR);
  assign bus.underflow    = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_graycounter_8_rdside.sv
`default_nettype none
// ============================================================================
//  Module   : tb_graycounter_8_rdside
//  Brief    : Directed self-checking bench for graycounter_8_rdside.
//  Revision : 1.0  initial release
// ============================================================================
module tb_graycounter_8_rdside;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  int   errors  = 0;
  int   checks  = 0;

  graycounter_8_rdside_if bus ();

  graycounter_8_rdside #(
    .SYNC_STAGES (2),
    .AEMPTY_LVL  (1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1 reset_n = 1'b0;
    #1;
    checks++; if (bus.rd_gray !== 5'b00000) begin errors++; $display("FAIL reset_rd_gray: got %b expected 00000", bus.rd_gray); end
    checks++; if (bus.rd_addr !== 3'd0) begin errors++; $display("FAIL reset_rd_addr: got %0d expected 0", bus.rd_addr); end
    checks++; if (bus.fill !== 3'd0) begin errors++; $display("FAIL reset_fill: got %0d expected 0", bus.fill); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", bus.empty); end
    checks++; if (bus.almost_empty !== 1'b1) begin errors++; $display("FAIL reset_almost_empty: got %b expected 1", bus.almost_empty); end
    checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %b expected 0", bus.underflow); end
    checks++; if (bus.code_err !== 1'b0) begin errors++; $display("FAIL reset_code_err: got %b expected 0", bus.code_err); end
    #6 reset_n = 1'b1;
  endtask

  task automatic test_fill_and_read;
    logic [4:0] exp_gray [3];
    exp_gray[0] = 5'b00001; exp_gray[1] = 5'b00011; exp_gray[2] = 5'b00010;
    bus.wr_gray = 5'b00010;
    tick(2);
    checks++; if (bus.fill !== 3'd0) begin errors++; $display("FAIL latency_fill_early: got %0d expected 0", bus.fill); end
    tick(1);
    checks++; if (bus.fill !== 3'd3) begin errors++; $display("FAIL fill_g3: got %0d expected 3", bus.fill); end
    checks++; if (bus.empty !== 1'b0) begin errors++; $display("FAIL empty_g3: got %b expected 0", bus.empty); end
    checks++; if (bus.almost_empty !== 1'b0) begin errors++; $display("FAIL aempty_g3: got %b expected 0", bus.almost_empty); end
    bus.rd_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      checks++; if (bus.rd_gray !== exp_gray[k]) begin errors++; $display("FAIL read_gray_%0d: got %b expected %b", k, bus.rd_gray, exp_gray[k]); end
      checks++; if (bus.rd_addr !== 3'(k + 1)) begin errors++; $display("FAIL read_addr_%0d: got %0d expected %0d", k, bus.rd_addr, k + 1); end
    end
    bus.rd_en = 1'b0;
    checks++; if (bus.fill !== 3'd0) begin errors++; $display("FAIL drained_fill: got %0d expected 0", bus.fill); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL drained_empty: got %b expected 1", bus.empty); end
  endtask

  task automatic test_underflow;
    bus.rd_en = 1'b1;
    tick(1);
    bus.rd_en = 1'b0;
    checks++; if (bus.underflow !== 1'b1) begin errors++; $display("FAIL underflow_pulse: got %b expected 1", bus.underflow); end
    checks++; if (bus.rd_addr !== 3'd3) begin errors++; $display("FAIL underflow_addr: got %0d expected 3", bus.rd_addr); end
    checks++; if (bus.rd_gray !== 5'b00010) begin errors++; $display("FAIL underflow_gray: got %b expected 00010", bus.rd_gray); end
    checks++; if (bus.fill !== 3'd0) begin errors++; $display("FAIL underflow_fill: got %0d expected 0", bus.fill); end
    tick(1);
    checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL underflow_clear: got %b expected 0", bus.underflow); end
  endtask

  task automatic test_wrap;
    bus.wr_gray = 5'b00101;
    tick(3);
    checks++; if (bus.fill !== 3'd3) begin errors++; $display("FAIL wrap_pre_fill: got %0d expected 3", bus.fill); end
    bus.rd_en = 1'b1;
    tick(3);
    bus.rd_en = 1'b0;
    checks++; if (bus.rd_gray !== 5'b00101) begin errors++; $display("FAIL wrap_at6_gray: got %b expected 00101", bus.rd_gray); end
    checks++; if (bus.rd_addr !== 3'd6) begin errors++; $display("FAIL wrap_at6_addr: got %0d expected 6", bus.rd_addr); end
    bus.wr_gray = 5'b00001;
    tick(3);
    checks++; if (bus.fill !== 3'd3) begin errors++; $display("FAIL wrap_fill: got %0d expected 3", bus.fill); end
    checks++; if (bus.almost_empty !== 1'b0) begin errors++; $display("FAIL wrap_aempty: got %b expected 0", bus.almost_empty); end
    bus.rd_en = 1'b1;
    tick(1);
    checks++; if (bus.rd_gray !== 5'b00100) begin errors++; $display("FAIL wrap_gray_g7: got %b expected 00100", bus.rd_gray); end
    tick(1);
    checks++; if (bus.rd_gray !== 5'b00000) begin errors++; $display("FAIL wrap_gray_g0: got %b expected 00000", bus.rd_gray); end
    checks++; if (bus.rd_addr !== 3'd0) begin errors++; $display("FAIL wrap_addr_0: got %0d expected 0", bus.rd_addr); end
    checks++; if (bus.almost_empty !== 1'b1) begin errors++; $display("FAIL wrap_aempty_fill1: got %b expected 1", bus.almost_empty); end
    checks++; if (bus.empty !== 1'b0) begin errors++; $display("FAIL wrap_empty_fill1: got %b expected 0", bus.empty); end
    tick(1);
    bus.rd_en = 1'b0;
    checks++; if (bus.rd_gray !== 5'b00001) begin errors++; $display("FAIL wrap_gray_g1: got %b expected 00001", bus.rd_gray); end
    checks++; if (bus.rd_addr !== 3'd1) begin errors++; $display("FAIL wrap_addr_1: got %0d expected 1", bus.rd_addr); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL wrap_empty_end: got %b expected 1", bus.empty); end
  endtask

  task automatic test_back_to_back;
    bus.wr_gray = 5'b00010;
    tick(3);
    checks++; if (bus.fill !== 3'd2) begin errors++; $display("FAIL b2b_fill_pre: got %0d expected 2", bus.fill); end
    bus.wr_gray = 5'b00111;
    tick(2);
    bus.rd_en = 1'b1;
    tick(1);
    bus.rd_en = 1'b0;
    checks++; if (bus.fill !== 3'd3) begin errors++; $display("FAIL b2b_fill: got %0d expected 3", bus.fill); end
    checks++; if (bus.rd_addr !== 3'd2) begin errors++; $display("FAIL b2b_addr: got %0d expected 2", bus.rd_addr); end
    checks++; if (bus.rd_gray !== 5'b00011) begin errors++; $display("FAIL b2b_gray: got %b expected 00011", bus.rd_gray); end
  endtask

  task automatic test_code_err;
    bus.wr_gray = 5'b11111;
    tick(2);
    checks++; if (bus.code_err !== 1'b0) begin errors++; $display("FAIL code_err_early: got %b expected 0", bus.code_err); end
    tick(1);
`ifdef GRAYRD_CHECK_EN
    checks++; if (bus.code_err !== 1'b1) begin errors++; $display("FAIL code_err_set: got %b expected 1", bus.code_err); end
    checks++; if (bus.fill !== 3'd3) begin errors++; $display("FAIL code_err_hold_fill: got %0d expected 3", bus.fill); end
`else
    checks++; if (bus.code_err !== 1'b0) begin errors++; $display("FAIL code_err_off: got %b expected 0", bus.code_err); end
    checks++; if (bus.fill !== 3'd5) begin errors++; $display("FAIL illegal_as_7_fill: got %0d expected 5", bus.fill); end
`endif
    bus.wr_gray = 5'b00111;
    tick(3);
`ifdef GRAYRD_CHECK_EN
    checks++; if (bus.code_err !== 1'b1) begin errors++; $display("FAIL code_err_sticky: got %b expected 1", bus.code_err); end
`else
    checks++; if (bus.code_err !== 1'b0) begin errors++; $display("FAIL code_err_stays_0: got %b expected 0", bus.code_err); end
`endif
    checks++; if (bus.fill !== 3'd3) begin errors++; $display("FAIL code_err_recover_fill: got %0d expected 3", bus.fill); end
  endtask

  task automatic test_reset_mid;
    bus.wr_gray = 5'b00101;
    tick(3);
    checks++; if (bus.fill !== 3'd4) begin errors++; $display("FAIL mid_fill4: got %0d expected 4", bus.fill); end
    #3 reset_n = 1'b0;
    #1;
    checks++; if (bus.rd_gray !== 5'b00000) begin errors++; $display("FAIL mid_rd_gray: got %b expected 00000", bus.rd_gray); end
    checks++; if (bus.rd_addr !== 3'd0) begin errors++; $display("FAIL mid_rd_addr: got %0d expected 0", bus.rd_addr); end
    checks++; if (bus.fill !== 3'd0) begin errors++; $display("FAIL mid_fill: got %0d expected 0", bus.fill); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL mid_empty: got %b expected 1", bus.empty); end
    checks++; if (bus.almost_empty !== 1'b1) begin errors++; $display("FAIL mid_aempty: got %b expected 1", bus.almost_empty); end
    checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL mid_underflow: got %b expected 0", bus.underflow); end
    checks++; if (bus.code_err !== 1'b0) begin errors++; $display("FAIL mid_code_err: got %b expected 0", bus.code_err); end
    #1 reset_n = 1'b1;
    tick(1);
    checks++; if (bus.fill !== 3'd0) begin errors++; $display("FAIL post_reset_fill: got %0d expected 0", bus.fill); end
    tick(2);
    checks++; if (bus.fill !== 3'd6) begin errors++; $display("FAIL post_reset_resync: got %0d expected 6", bus.fill); end
    checks++; if (bus.almost_empty !== 1'b0) begin errors++; $display("FAIL post_reset_aempty: got %b expected 0", bus.almost_empty); end
  endtask

  initial begin
    bus.wr_gray = 5'b00000;
    bus.rd_en   = 1'b0;
    test_reset();
    test_fill_and_read();
    test_underflow();
    test_wrap();
    test_back_to_back();
    test_code_err();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
